// File: rtl/sin_linear_pkg.sv
// Shared constants and types for the sin_linear request arbiter.
package sin_linear_pkg;

   localparam logic [31:0] COS_OFFSET = 32'h4000_0000;
   localparam int DEFAULT_CORE_LAT = 3;
   localparam int DEF_OUTPUT_WIDTH = 32;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_ID_W = id_width(4);

   typedef struct packed {
      logic [DEF_ID_W-1:0]         id;
      logic [DEF_OUTPUT_WIDTH-1:0] result;
   } res_word_t;

endpackage

// File: rtl/sin_linear_arbiter_if.sv
// Request, core and result signals of the sin_linear arbiter; slave is the arbiter side.
interface sin_linear_arbiter_if #(
   parameter int NUM_REQ      = 4,
   parameter int OUTPUT_WIDTH = 32,
   parameter int ID_W         = sin_linear_pkg::id_width(NUM_REQ)
);
   logic [NUM_REQ-1:0]      req_valid_i;
   logic [32*NUM_REQ-1:0]   req_phase_i;
   logic [NUM_REQ-1:0]      req_cos_i;
   logic [NUM_REQ-1:0]      req_ready_o;
   logic [31:0]             core_phase_o;
   logic                    core_valid_o;
   logic [OUTPUT_WIDTH-1:0] core_result_i;
   logic                    core_valid_i;
   logic                    res_valid_o;
   logic                    res_ready_i;
   logic [OUTPUT_WIDTH-1:0] res_data_o;
   logic [ID_W-1:0]         res_id_o;
   logic                    err_o;

   modport slave (
      input  req_valid_i, req_phase_i, req_cos_i, core_result_i, core_valid_i, res_ready_i,
      output req_ready_o, core_phase_o, core_valid_o, res_valid_o, res_data_o, res_id_o, err_o
   );

   modport master (
      output req_valid_i, req_phase_i, req_cos_i, core_result_i, core_valid_i, res_ready_i,
      input  req_ready_o, core_phase_o, core_valid_o, res_valid_o, res_data_o, res_id_o, err_o
   );
endinterface

// File: rtl/sin_res_fifo.sv
// Synchronous result FIFO; the head word is held in an output register so
// data/valid come straight from flops and stay put while the consumer stalls.
module sin_res_fifo
   import sin_linear_pkg::*;
#(
   parameter type word_t = res_word_t,
   parameter int  DEPTH  = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  word_t                  push_data,
   input  logic                   pop,
   output word_t                  out_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PW = $clog2(DEPTH);

   word_t          mem_r [DEPTH];
   word_t          out_r;
   word_t          head_n_s;
   logic [PW-1:0]  wr_ptr_r;
   logic [PW-1:0]  rd_ptr_r;
   logic [PW-1:0]  rd_ptr_n_s;
   logic [PW:0]    count_r;
   logic [PW:0]    keep_s;
   logic [PW:0]    count_n_s;
   logic           full_r;
   logic           empty_r;
   logic           push_ok_s;
   logic           pop_ok_s;

   // An empty FIFO bypasses the pushed word straight into the head register.
   always_comb begin
      push_ok_s  = push & ~full_r;
      pop_ok_s   = pop & ~empty_r;
      rd_ptr_n_s = pop_ok_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
      keep_s     = count_r - {{PW{1'b0}}, pop_ok_s};
      count_n_s  = keep_s + {{PW{1'b0}}, push_ok_s};
      if (keep_s == '0) begin
         head_n_s = push_ok_s ? push_data : out_r;
      end else begin
         head_n_s = mem_r[rd_ptr_n_s];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         out_r    <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         out_r    <= head_n_s;
         rd_ptr_r <= rd_ptr_n_s;
         count_r  <= count_n_s;
         full_r   <= (count_n_s == (PW+1)'(DEPTH));
         empty_r  <= (count_n_s == '0);
      end
   end

   assign out_data = out_r;
   assign count    = count_r;
   assign full     = full_r;
   assign empty    = empty_r;
endmodule

// File: rtl/sin_linear_arbiter.sv
// Round-robin sharing of one pipelined sin_linear core among NUM_REQ requesters,
// with credit-gated issue, an ID tag pipe and an in-order result FIFO.
module sin_linear_arbiter
   import sin_linear_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int OUTPUT_WIDTH = 32,
   parameter int CORE_LAT     = DEFAULT_CORE_LAT,
   parameter int FIFO_DEPTH   = 8,
   parameter int ID_W         = id_width(NUM_REQ)
) (
   input logic                 clk,
   input logic                 resetn,
   sin_linear_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 2;

   typedef struct packed {
      logic [ID_W-1:0]         id;
      logic [OUTPUT_WIDTH-1:0] result;
   } word_t;

   logic [ID_W-1:0]            ptr_r;
   logic [ID_W-1:0]            grant_id_s;
   logic [ID_W-1:0]            cand_s;
   logic                       grant_found_s;
   logic                       hit_s;
   logic                       credit_ok_s;
   logic                       xfer_s;
   logic [31:0]                sel_phase_s;
   logic                       sel_cos_s;
   logic                       core_valid_r;
   logic [31:0]                core_phase_r;
   logic [ID_W-1:0]            issue_id_r;
   logic [CORE_LAT-1:0]        tag_valid_r;
   logic [ID_W-1:0]            tag_id_r [CORE_LAT];
   logic                       ret_s;
   logic [CNT_W-1:0]           inflight_r;
   logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
   logic                       fifo_full_s;
   logic                       fifo_empty_s;
   logic                       err_r;
   logic                       err_set_s;
   word_t                      push_word_s;
   word_t                      out_word_s;

   assign credit_ok_s = (CNT_W'(fifo_count_s) + inflight_r) < CNT_W'(FIFO_DEPTH);

   // First asserted request after the pointer, with wrap-around.
   always_comb begin
      grant_found_s = 1'b0;
      grant_id_s    = '0;
      cand_s        = '0;
      hit_s         = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s        = ID_W'((int'(ptr_r) + k) % NUM_REQ);
         hit_s         = ~grant_found_s & bus.req_valid_i[cand_s];
         grant_id_s    = hit_s ? cand_s : grant_id_s;
         grant_found_s = grant_found_s | hit_s;
      end
   end

   always_comb begin
      sel_phase_s = 32'h0000_0000;
      sel_cos_s   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_phase_s = (grant_id_s == ID_W'(i)) ? bus.req_phase_i[32*i +: 32] : sel_phase_s;
         sel_cos_s   = (grant_id_s == ID_W'(i)) ? bus.req_cos_i[i] : sel_cos_s;
      end
   end

   assign xfer_s          = grant_found_s & credit_ok_s;
   assign bus.req_ready_o = xfer_s ? (NUM_REQ'(1) << grant_id_s) : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr_r        <= ID_W'(NUM_REQ - 1);
         core_valid_r <= 1'b0;
         core_phase_r <= 32'h0000_0000;
         issue_id_r   <= '0;
      end else begin
         core_valid_r <= xfer_s;
         issue_id_r   <= grant_id_s;
         if (xfer_s) begin
            ptr_r        <= grant_id_s;
            core_phase_r <= sel_phase_s + (sel_cos_s ? COS_OFFSET : 32'h0000_0000);
         end
      end
   end

   // The issue register is the first tag stage; the last stage lines up with core_valid_i.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tag_valid_r <= '0;
         for (int i = 0; i < CORE_LAT; i++) begin
            tag_id_r[i] <= '0;
         end
      end else begin
         tag_valid_r[0] <= core_valid_r;
         tag_id_r[0]    <= issue_id_r;
         for (int i = 1; i < CORE_LAT; i++) begin
            tag_valid_r[i] <= tag_valid_r[i-1];
            tag_id_r[i]    <= tag_id_r[i-1];
         end
      end
   end

   assign ret_s     = tag_valid_r[CORE_LAT-1];
   assign err_set_s = (bus.core_valid_i != ret_s) | (bus.core_valid_i & fifo_full_s);

   // Returns are counted from the tag so a spurious core_valid_i cannot underflow.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inflight_r <= '0;
         err_r      <= 1'b0;
      end else begin
         case ({xfer_s, ret_s})
            2'b10:   inflight_r <= inflight_r + CNT_W'(1);
            2'b01:   inflight_r <= inflight_r - CNT_W'(1);
            default: inflight_r <= inflight_r;
         endcase
         err_r <= err_r | err_set_s;
      end
   end

   assign push_word_s.id     = tag_id_r[CORE_LAT-1];
   assign push_word_s.result = bus.core_result_i;

   sin_res_fifo #(
      .word_t (word_t),
      .DEPTH  (FIFO_DEPTH)
   ) u_res_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (bus.core_valid_i),
      .push_data (push_word_s),
      .pop       (bus.res_ready_i),
      .out_data  (out_word_s),
      .count     (fifo_count_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   assign bus.core_valid_o = core_valid_r;
   assign bus.core_phase_o = core_phase_r;
   assign bus.res_valid_o  = ~fifo_empty_s;
   assign bus.res_data_o   = out_word_s.result;
   assign bus.res_id_o     = out_word_s.id;
   assign bus.err_o        = err_r;
endmodule

// File: tb/tb_sin_linear_arbiter.sv
// Scoreboard bench for sin_linear_arbiter with a behavioural 3-cycle core model.
module tb_sin_linear_arbiter;
   localparam int NUM_REQ = 4;
   localparam int OW      = 32;
   localparam int LAT     = 3;
   localparam int DEPTH   = 8;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          cyc;
   } ent_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic inject = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ent_t exp_q[$];
   ent_t obs_q[$];
   ent_t mon_e;

   logic [LAT-1:0] cv_r;
   logic [31:0]    cp_r [LAT];

   always #5 clk = ~clk;

   sin_linear_arbiter_if #(.NUM_REQ(NUM_REQ), .OUTPUT_WIDTH(OW)) bus ();

   sin_linear_arbiter #(
      .NUM_REQ(NUM_REQ), .OUTPUT_WIDTH(OW), .CORE_LAT(LAT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   function automatic logic [31:0] core_fn(input logic [31:0] p);
      return {p[15:0], p[31:16]} ^ 32'h0F0F_0F0F;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cv_r <= '0;
         for (int i = 0; i < LAT; i++) cp_r[i] <= 32'h0;
      end else begin
         cv_r[0] <= bus.core_valid_o;
         cp_r[0] <= bus.core_phase_o;
         for (int i = 1; i < LAT; i++) begin
            cv_r[i] <= cv_r[i-1];
            cp_r[i] <= cp_r[i-1];
         end
      end
   end

   assign bus.core_valid_i  = cv_r[LAT-1] | inject;
   assign bus.core_result_i = core_fn(cp_r[LAT-1]);

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (resetn && bus.res_valid_o && bus.res_ready_i) begin
         mon_e.id   = int'(bus.res_id_o);
         mon_e.data = bus.res_data_o;
         mon_e.cyc  = cyc;
         obs_q.push_back(mon_e);
      end
   end

   task automatic push_exp(input int id, input logic [31:0] phase);
      ent_t e;
      e.id   = id;
      e.data = core_fn(phase);
      e.cyc  = cyc;
      exp_q.push_back(e);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      bus.req_valid_i = 4'b1111;
      @(negedge clk);
      checks++; if (bus.core_valid_o !== 1'b0) begin errors++; $display("FAIL reset_core_valid: got %0b expected 0", bus.core_valid_o); end
      checks++; if (bus.core_phase_o !== 32'h0) begin errors++; $display("FAIL reset_core_phase: got %0h expected 0", bus.core_phase_o); end
      checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b expected 0", bus.res_valid_o); end
      checks++; if (bus.res_data_o !== 32'h0) begin errors++; $display("FAIL reset_res_data: got %0h expected 0", bus.res_data_o); end
      checks++; if (bus.res_id_o !== 2'd0) begin errors++; $display("FAIL reset_res_id: got %0d expected 0", bus.res_id_o); end
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", bus.err_o); end
      checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL reset_priority: got %b expected 0001", bus.req_ready_o); end
      @(posedge clk); #1;
      bus.req_valid_i = 4'b0000;
      resetn = 1'b1;
   endtask

   task automatic test_single(input string nm, input int id, input logic [31:0] phase,
                              input logic cos, input logic [31:0] exp_core);
      ent_t e, o;
      @(posedge clk); #1;
      bus.req_valid_i = 4'b0001 << id;
      bus.req_phase_i[32*id +: 32] = phase;
      bus.req_cos_i = {3'b000, cos} << id;
      @(negedge clk);
      checks++; if (bus.req_ready_o !== (4'b0001 << id)) begin errors++; $display("FAIL %s_ready: got %b expected %b", nm, bus.req_ready_o, 4'b0001 << id); end
      push_exp(id, exp_core);
      @(posedge clk); #1;
      bus.req_valid_i = 4'b0000;
      @(negedge clk);
      checks++; if (bus.core_valid_o !== 1'b1) begin errors++; $display("FAIL %s_core_valid: got %0b expected 1", nm, bus.core_valid_o); end
      checks++; if (bus.core_phase_o !== exp_core) begin errors++; $display("FAIL %s_core_phase: got %h expected %h", nm, bus.core_phase_o, exp_core); end
      for (int w = 0; w < 40 && obs_q.size() < exp_q.size(); w++) @(negedge clk);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count: got %0d expected %0d", nm, obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.id != e.id || o.data !== e.data || o.cyc - e.cyc != LAT + 2) begin
            errors++;
            $display("FAIL %s_result: got id %0d data %h lat %0d expected id %0d data %h lat %0d",
                     nm, o.id, o.data, o.cyc - e.cyc, e.id, e.data, LAT + 2);
         end
      end
   endtask

   task automatic test_fairness();
      ent_t e, o;
      logic [31:0] ph;
      pulse_reset();
      bus.res_ready_i = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) bus.req_phase_i[32*i +: 32] = 32'h1000_0000 * i + 32'h123;
      bus.req_cos_i   = 4'b1010;
      bus.req_valid_i = 4'b1111;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (bus.req_ready_o !== (4'b0001 << (k % NUM_REQ))) begin
            errors++; $display("FAIL fair_grant%0d: got %b expected %b", k, bus.req_ready_o, 4'b0001 << (k % NUM_REQ));
         end
         ph = 32'h1000_0000 * (k % NUM_REQ) + 32'h123 + (((k % NUM_REQ) % 2 == 1) ? 32'h4000_0000 : 32'h0);
         push_exp(k % NUM_REQ, ph);
         @(posedge clk); #1;
      end
      bus.req_valid_i = 4'b0000;
      for (int w = 0; w < 40 && obs_q.size() < exp_q.size(); w++) @(negedge clk);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL fair_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.id != e.id || o.data !== e.data || o.cyc - e.cyc != LAT + 2) begin
            errors++;
            $display("FAIL fair_result: got id %0d data %h lat %0d expected id %0d data %h lat %0d",
                     o.id, o.data, o.cyc - e.cyc, e.id, e.data, LAT + 2);
         end
      end
   endtask

   task automatic test_backpressure();
      ent_t e, o;
      int n_xfer = 0;
      int n_resume = 0;
      logic [31:0] ph;
      bus.res_ready_i = 1'b0;
      bus.req_cos_i   = 4'b0000;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk); #1;
         ph = 32'h0100_0000 * (k + 1) + 32'h55;
         bus.req_phase_i[63:32] = ph;
         bus.req_valid_i = 4'b0010;
         @(negedge clk);
         checks++;
         if (bus.req_ready_o !== ((k < DEPTH) ? 4'b0010 : 4'b0000)) begin
            errors++; $display("FAIL bp_ready%0d: got %b expected %b", k, bus.req_ready_o, (k < DEPTH) ? 4'b0010 : 4'b0000);
         end
         if (bus.req_ready_o[1]) begin
            n_xfer++;
            push_exp(1, ph);
         end
      end
      checks++; if (n_xfer != DEPTH) begin errors++; $display("FAIL bp_xfers: got %0d expected %0d", n_xfer, DEPTH); end
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL bp_err: got %0b expected 0", bus.err_o); end
      checks++; if (bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL bp_res_valid: got %0b expected 1", bus.res_valid_o); end
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         bus.res_ready_i = 1'b1;
         ph = 32'h0200_0000 * (k + 1) + 32'h77;
         bus.req_phase_i[63:32] = ph;
         @(negedge clk);
         if (bus.req_ready_o[1]) begin
            n_resume++;
            push_exp(1, ph);
         end
      end
      @(posedge clk); #1;
      bus.req_valid_i = 4'b0000;
      checks++; if (n_resume == 0) begin errors++; $display("FAIL bp_resume: got %0d transfers expected more than 0", n_resume); end
      for (int w = 0; w < 60 && obs_q.size() < exp_q.size(); w++) @(negedge clk);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.id != e.id || o.data !== e.data) begin
            errors++; $display("FAIL bp_result: got id %0d data %h expected id %0d data %h", o.id, o.data, e.id, e.data);
         end
      end
   endtask

   task automatic test_reset_midflight();
      int n_valid = 0;
      bus.res_ready_i = 1'b1;
      bus.req_cos_i   = 4'b0000;
      bus.req_phase_i[31:0] = 32'h1111_2222;
      @(posedge clk); #1;
      bus.req_valid_i = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL mid_ready%0d: got %b expected 0001", k, bus.req_ready_o); end
         @(posedge clk); #1;
      end
      bus.req_valid_i = 4'b0000;
      resetn = 1'b0;
      @(negedge clk);
      checks++; if (bus.core_valid_o !== 1'b0) begin errors++; $display("FAIL mid_core_valid: got %0b expected 0", bus.core_valid_o); end
      checks++; if (bus.core_phase_o !== 32'h0) begin errors++; $display("FAIL mid_core_phase: got %h expected 0", bus.core_phase_o); end
      checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL mid_res_valid: got %0b expected 0", bus.res_valid_o); end
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL mid_err: got %0b expected 0", bus.err_o); end
      @(posedge clk); @(posedge clk); #1;
      resetn = 1'b1;
      exp_q.delete();
      obs_q.delete();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.res_valid_o) n_valid++;
      end
      checks++; if (n_valid != 0) begin errors++; $display("FAIL mid_stale: got %0d result cycles expected 0", n_valid); end
   endtask

   task automatic test_error();
      @(posedge clk); #1;
      inject = 1'b1;
      @(negedge clk);
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL err_early: got %0b expected 0", bus.err_o); end
      @(posedge clk); #1;
      inject = 1'b0;
      @(negedge clk);
      checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %0b expected 1", bus.err_o); end
      repeat (5) @(negedge clk);
      checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", bus.err_o); end
      pulse_reset();
      @(negedge clk);
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b expected 0", bus.err_o); end
   endtask

   initial begin
      bus.req_valid_i = 4'b0000;
      bus.req_phase_i = '0;
      bus.req_cos_i   = 4'b0000;
      bus.res_ready_i = 1'b1;
      test_reset();
      test_single("sin", 0, 32'h4000_0000, 1'b0, 32'h4000_0000);
      test_single("cos", 2, 32'hE000_0000, 1'b1, 32'h2000_0000);
      test_fairness();
      test_backpressure();
      test_reset_midflight();
      test_error();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
